// File: rtl/serial_byte_tx_if.sv
// Parallel byte hand-off into the serial transmitter: valid/ready handshake.
interface serial_byte_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_byte_tx.sv
// Bit-serial byte transmitter: accepts one byte, waits for the peer, then shifts it out
// LSB first with one write strobe per bit. All outputs are registered.
module serial_byte_tx #(
  parameter int START_DLY    = 10,
  parameter int WR_HIGH_CYC  = 10,
  parameter int WR_LOW_CYC   = 10,
  parameter int DROP_TIMEOUT = 64
) (
  input  logic              i_clock_1MHz,
  input  logic              i_rst,          // active-low, asynchronous
  serial_byte_tx_if.slave   tx_if,
  input  logic              i_peer_ready,
  output logic              o_data_out,
  output logic              o_write_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_abort,
  output logic              o_timeout_err
);

  localparam int MAX_A   = (START_DLY > WR_HIGH_CYC) ? START_DLY : WR_HIGH_CYC;
  localparam int MAX_B   = (WR_LOW_CYC > DROP_TIMEOUT) ? WR_LOW_CYC : DROP_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] START_LAST = CW'(START_DLY - 1);
  localparam logic [CW-1:0] HI_LAST    = CW'(WR_HIGH_CYC - 1);
  localparam logic [CW-1:0] LO_LAST    = CW'(WR_LOW_CYC - 1);
  localparam logic [CW-1:0] DROP_LAST  = CW'(DROP_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_START,
    S_BIT_HI,
    S_BIT_LO,
    S_WAIT_DROP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic          r_data_out;
  logic          r_write_out;
  logic          r_busy;
  logic          r_done;
  logic          r_abort;
  logic          r_timeout_err;
  logic          r_tx_ready;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_idx_next;
  logic [7:0]    w_sh_next;
  logic          w_data_next;
  logic          w_write_next;
  logic          w_done_next;
  logic          w_abort_next;
  logic          w_timeout_next;
  logic          w_busy_next;
  logic          w_tx_ready_next;
  logic          w_accept;
  logic          w_drop_abort;

  assign w_accept     = tx_if.tx_valid && r_tx_ready;
  // Peer losing readiness while a byte is being clocked out kills the byte.
  assign w_drop_abort = !i_peer_ready &&
                        ((r_state == S_START) || (r_state == S_BIT_HI) || (r_state == S_BIT_LO));

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_sh_next      = r_sh;
    w_data_next    = r_data_out;
    w_write_next   = r_write_out;
    w_done_next    = 1'b0;
    w_abort_next   = 1'b0;
    w_timeout_next = r_timeout_err;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sh_next      = tx_if.tx_data;
          w_timeout_next = 1'b0;
          w_state_next   = S_WAIT_RDY;
        end
      end

      S_WAIT_RDY: begin
        if (i_peer_ready) begin
          w_cnt_next   = '0;
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (r_cnt == START_LAST) begin
          w_data_next  = r_sh[0];
          w_write_next = 1'b1;
          w_idx_next   = 3'd0;
          w_cnt_next   = '0;
          w_state_next = S_BIT_HI;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      S_BIT_HI: begin
        if (r_cnt == HI_LAST) begin
          w_write_next = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_BIT_LO;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      S_BIT_LO: begin
        if (r_cnt == LO_LAST) begin
          w_cnt_next = '0;
          if (r_idx != 3'd7) begin
            // Next bit and its strobe rise on the same edge.
            w_sh_next    = r_sh >> 1;
            w_idx_next   = r_idx + 3'd1;
            w_data_next  = r_sh[1];
            w_write_next = 1'b1;
            w_state_next = S_BIT_HI;
          end else begin
            w_done_next  = 1'b1;
            w_data_next  = 1'b0;
            w_state_next = S_WAIT_DROP;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      S_WAIT_DROP: begin
        if (!i_peer_ready) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else if (r_cnt == DROP_LAST) begin
          w_timeout_next = 1'b1;
          w_cnt_next     = '0;
          w_state_next   = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything decided above, including a pending done.
    if (w_drop_abort) begin
      w_state_next = S_IDLE;
      w_data_next  = 1'b0;
      w_write_next = 1'b0;
      w_done_next  = 1'b0;
      w_abort_next = 1'b1;
      w_cnt_next   = '0;
    end

    w_busy_next     = (w_state_next != S_IDLE);
    w_tx_ready_next = (w_state_next == S_IDLE);
  end

  always_ff @(posedge i_clock_1MHz or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_sh          <= 8'd0;
      r_data_out    <= 1'b0;
      r_write_out   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_abort       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tx_ready    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_idx         <= w_idx_next;
      r_sh          <= w_sh_next;
      r_data_out    <= w_data_next;
      r_write_out   <= w_write_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_abort       <= w_abort_next;
      r_timeout_err <= w_timeout_next;
      r_tx_ready    <= w_tx_ready_next;
    end
  end

  assign tx_if.tx_ready = r_tx_ready;
  assign o_data_out     = r_data_out;
  assign o_write_out    = r_write_out;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_abort        = r_abort;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Scoreboard bench for serial_byte_tx: a negedge monitor rebuilds each byte from the
// strobes, checks pulse widths and timing, and retires expected entries on done/abort.
module tb_serial_byte_tx;

  localparam int SD = 10;
  localparam int WH = 10;
  localparam int WL = 10;
  localparam int DT = 64;
  localparam int BYTE_CYC = SD + 8 * (WH + WL);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic peer_ready = 1'b0;
  logic data_out, write_out, busy, done, abort, timeout_err;

  serial_byte_tx_if tx_if ();

  serial_byte_tx #(
    .START_DLY(SD), .WR_HIGH_CYC(WH), .WR_LOW_CYC(WL), .DROP_TIMEOUT(DT)
  ) dut (
    .i_clock_1MHz (clk),
    .i_rst        (rst_n),
    .tx_if        (tx_if.slave),
    .i_peer_ready (peer_ready),
    .o_data_out   (data_out),
    .o_write_out  (write_out),
    .o_busy       (busy),
    .o_done       (done),
    .o_abort      (abort),
    .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         abort_exp;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor state
  int         hi_cnt = 0, lo_cnt = 0, nbits = 0;
  logic [7:0] bits = 8'h00;
  logic       prev_wr = 1'b0, in_lo = 1'b0, cur_bit = 1'b0;
  int         done_cnt = 0, abort_cnt = 0, last_done_cyc = 0;
  int         exp_done_cyc = 0, exp_first_cyc = 0;

  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      hi_cnt = 0; lo_cnt = 0; nbits = 0; prev_wr = 1'b0; in_lo = 1'b0; bits = 8'h00;
    end else if (abort) begin
      if (sb_q.size() == 0) begin
        check_eq("unexp_abort", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("abort_kind", 1, {31'd0, e.abort_exp});
        $display("abort  byte=%02h after %0d bits", e.data, nbits);
      end
      abort_cnt++;
      hi_cnt = 0; lo_cnt = 0; nbits = 0; prev_wr = 1'b0; in_lo = 1'b0;
    end else begin
      if (write_out && !prev_wr) begin
        if (in_lo) check_eq("lo_width", lo_cnt, WL);
        if (nbits == 0 && exp_first_cyc != 0) begin
          check_eq("first_strobe_cyc", cyc, exp_first_cyc);
          exp_first_cyc = 0;
        end
        if (nbits < 8) bits[nbits] = data_out;
        nbits++;
        cur_bit = data_out;
        hi_cnt = 1;
        in_lo = 1'b0;
      end else if (write_out) begin
        check_eq("data_hold", data_out, cur_bit);
        hi_cnt++;
      end else if (prev_wr) begin
        check_eq("hi_width", hi_cnt, WH);
        in_lo = 1'b1;
        lo_cnt = 1;
      end else if (in_lo) begin
        lo_cnt++;
      end
      if (done) begin
        check_eq("pulse_count", nbits, 8);
        if (sb_q.size() == 0) begin
          check_eq("unexp_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("done_kind", 0, {31'd0, e.abort_exp});
          check_eq("byte", bits, e.data);
          $display("done   byte=%02h exp=%02h cyc=%0d", bits, e.data, cyc);
        end
        if (exp_done_cyc != 0) begin
          check_eq("done_cyc", cyc, exp_done_cyc);
          exp_done_cyc = 0;
        end
        done_cnt++;
        last_done_cyc = cyc;
        nbits = 0; in_lo = 1'b0;
      end
      prev_wr = write_out;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_abort);
    int n = 0;
    while (!tx_if.tx_ready && n < 200) begin
      tick();
      n++;
    end
    check_eq("ready_wait", tx_if.tx_ready, 1);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    sb_q.push_back('{b, exp_abort});
    tick();
    tx_if.tx_valid = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_rdy", tx_if.tx_ready, 0);
  endtask

  task automatic wait_done(input int limit);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < limit) begin
      tick();
      n++;
    end
    check_eq("done_seen", (done_cnt != start), 1);
  endtask

  task automatic wait_nbits(input int target, input int limit);
    int n = 0;
    while (nbits < target && n < limit) begin
      tick();
      n++;
    end
    check_eq("nbits_wait", (nbits >= target), 1);
  endtask

  task automatic start_peer();
    peer_ready    = 1'b1;
    exp_done_cyc  = cyc + BYTE_CYC + 1;
    exp_first_cyc = cyc + SD + 1;
  endtask

  task automatic release_peer();
    peer_ready = 1'b0;
    tick();
    check_eq("idle_rdy", tx_if.tx_ready, 1);
    check_eq("idle_busy", busy, 0);
    tick();
  endtask

  initial begin
    logic [7:0] bytes [4];
    int viol;
    int n;
    int a0;

    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;

    // Reset values
    repeat (3) tick();
    check_eq("rst_tx_ready", tx_if.tx_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_write", write_out, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_abort", abort, 0);
    check_eq("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", tx_if.tx_ready, 1);

    // 0xAA, peer ready 5 cycles after acceptance
    send_byte(8'hAA, 1'b0);
    repeat (4) tick();
    start_peer();
    wait_done(BYTE_CYC + 20);
    tick();
    check_eq("no_timeout", timeout_err, 0);
    release_peer();

    // In-order stream of bytes
    bytes[0] = 8'h3C;
    bytes[1] = 8'hFF;
    bytes[2] = 8'($urandom_range(0, 255));
    bytes[3] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], 1'b0);
      start_peer();
      wait_done(BYTE_CYC + 20);
      release_peer();
    end

    // Peer drops during bit 3 high phase
    send_byte(8'h5A, 1'b1);
    start_peer();
    exp_done_cyc = 0;
    a0 = done_cnt;
    wait_nbits(4, 200);
    repeat (3) tick();
    peer_ready = 1'b0;
    tick();
    check_eq("abort_write", write_out, 0);
    check_eq("abort_data", data_out, 0);
    check_eq("abort_pulse", abort, 1);
    check_eq("abort_rdy", tx_if.tx_ready, 1);
    tick();
    check_eq("abort_1cyc", abort, 0);
    check_eq("abort_no_done", done_cnt - a0, 0);
    exp_first_cyc = 0;

    // Peer stays ready after done -> sticky timeout, cleared on next accept
    send_byte(8'h96, 1'b0);
    start_peer();
    wait_done(BYTE_CYC + 20);
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    check_eq("timeout_set", timeout_err, 1);
    check_eq("timeout_cyc", cyc - last_done_cyc, DT);
    check_eq("timeout_idle", tx_if.tx_ready, 1);
    repeat (3) tick();
    check_eq("timeout_sticky", timeout_err, 1);
    send_byte(8'h01, 1'b0);
    check_eq("timeout_clr", timeout_err, 0);
    exp_done_cyc  = cyc + BYTE_CYC + 1;
    exp_first_cyc = cyc + SD + 1;
    wait_done(BYTE_CYC + 20);
    release_peer();

    // Asynchronous reset during bit 5
    send_byte(8'hC3, 1'b0);
    start_peer();
    wait_nbits(6, 300);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_write", write_out, 0);
    check_eq("arst_data", data_out, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", tx_if.tx_ready, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_abort", abort, 0);
    check_eq("arst_timeout", timeout_err, 0);
    tick();
    sb_q.delete();
    exp_done_cyc  = 0;
    exp_first_cyc = 0;
    peer_ready    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("arst_release_rdy", tx_if.tx_ready, 1);
    send_byte(8'h01, 1'b0);
    start_peer();
    wait_done(BYTE_CYC + 20);
    release_peer();

    // Back-to-back with tx_valid held high
    tx_if.tx_data  = 8'hE7;
    tx_if.tx_valid = 1'b1;
    sb_q.push_back('{8'hE7, 1'b0});
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    check_eq("b2b_first_acc", busy, 1);
    tx_if.tx_data = 8'h18;
    sb_q.push_back('{8'h18, 1'b0});
    start_peer();
    wait_done(BYTE_CYC + 20);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_if.tx_ready || !busy) viol++;
    end
    check_eq("b2b_held_off", viol, 0);
    peer_ready = 1'b0;
    tick();
    check_eq("b2b_rdy_after_drop", tx_if.tx_ready, 1);
    tick();
    check_eq("b2b_second_acc", busy, 1);
    tx_if.tx_valid = 1'b0;
    viol = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (write_out) viol++;
    end
    check_eq("b2b_no_early_strobe", viol, 0);
    start_peer();
    wait_done(BYTE_CYC + 20);
    release_peer();

    check_eq("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
